lottery_checker_param: RTL and testbench

//  Parametrised lottery-ticket checker: collects NUM_DIGITS decimal digits one per insert edge,

---
 rtl/lottery_checker_param.sv | 160 ++++++++++++++++
 tb/tb_lottery_checker_param.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/lottery_checker_param.sv
// lottery_checker_param
//   Lottery-ticket checker. Collects NUM_DIGITS decimal digits, one per rising
//   edge of insert. Once the ticket is full and finish is seen, it compares the
//   ticket position by position against a loadable secret and grades the match
//   count into a prize tier. The result is held until new_game.
//
// Ports
//   clk, reset   : clock (rising edge) and synchronous active-high reset
//   num          : digit to insert (values > 9 are rejected)
//   insert       : level input; each rising edge inserts num
//   finish       : level input; requests evaluation once the ticket is full
//   new_game     : level input; leaves RESULT and starts a new ticket
//   load_secret  : loads secret_in, only in ENTRY with no digits entered yet
//   secret_in    : new secret, digit k at [k*DIGIT_W +: DIGIT_W]
//   digits       : digits entered so far, unentered positions read 0
//   digit_count  : number of digits entered
//   match_count  : matching positions (valid while done)
//   prize        : 0 none, 1 prize1, 2 prize2, 3 jackpot (valid while done)
//   win          : prize != 0 (valid while done)
//   done         : high while a result is held
//   bad_digit    : one-cycle pulse after an insert edge with num > 9
//   games_played : completed evaluations, saturates at all-ones

// Per-position digit comparator, one instance per ticket position.
module lottery_digit_cmp #(
  parameter int DIGIT_W = 4
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic               eq
);
  assign eq = (a == b);
endmodule

module lottery_checker_param #(
  parameter int                                NUM_DIGITS  = 5,
  parameter int                                DIGIT_W     = 4,
  parameter int                                PRIZE1_MIN  = 4,
  parameter int                                PRIZE2_MIN  = 3,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0]     SECRET_INIT = 20'h76905,
  parameter int                                CNT_W       = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [DIGIT_W-1:0]                   num,
  input  logic                                 insert,
  input  logic                                 finish,
  input  logic                                 new_game,
  input  logic                                 load_secret,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]        secret_in,
  output logic [NUM_DIGITS*DIGIT_W-1:0]        digits,
  output logic [$clog2(NUM_DIGITS+1)-1:0]      digit_count,
  output logic [$clog2(NUM_DIGITS+1)-1:0]      match_count,
  output logic [1:0]                           prize,
  output logic                                 win,
  output logic                                 done,
  output logic                                 bad_digit,
  output logic [CNT_W-1:0]                     games_played
);

  localparam int CW = $clog2(NUM_DIGITS+1);

  typedef enum logic [1:0] {ENTRY, READY, CHECK, RESULT} state_t;

  state_t                                  state;
  logic                                    insert_q;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0]      dig_q;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0]      secret_q;
  logic [NUM_DIGITS-1:0]                   eq;
  logic [CW-1:0]                           match_c;
  logic [1:0]                              prize_c;
  logic                                    ins_edge;

  assign ins_edge = insert & ~insert_q;
  assign digits   = dig_q;

  // One comparator per ticket position.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_cmp
    lottery_digit_cmp #(.DIGIT_W(DIGIT_W)) u_cmp (
      .a  (dig_q[k]),
      .b  (secret_q[k]),
      .eq (eq[k])
    );
  end

  // Popcount of matching positions and prize grading. These are only
  // consumed in CHECK, when the ticket is complete and stable.
  always_comb begin
    match_c = '0;
    for (int k = 0; k < NUM_DIGITS; k++)
      match_c = match_c + CW'(eq[k]);
    prize_c = 2'd0;
    if (match_c == CW'(NUM_DIGITS))       prize_c = 2'd3;
    else if (match_c >= CW'(PRIZE1_MIN))  prize_c = 2'd1;
    else if (match_c >= CW'(PRIZE2_MIN))  prize_c = 2'd2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ENTRY;
      insert_q     <= 1'b0;
      dig_q        <= '0;
      secret_q     <= SECRET_INIT;
      digit_count  <= '0;
      match_count  <= '0;
      prize        <= 2'd0;
      win          <= 1'b0;
      done         <= 1'b0;
      bad_digit    <= 1'b0;
      games_played <= '0;
    end else begin
      // Edge detector runs in every state, so a level held across new_game
      // cannot produce an insert in the next ticket.
      insert_q  <= insert;
      bad_digit <= 1'b0;
      unique case (state)
        ENTRY: begin
          if (load_secret && digit_count == '0)
            secret_q <= secret_in;
          if (ins_edge) begin
            if (num > DIGIT_W'(9)) begin
              bad_digit <= 1'b1;
            end else begin
              for (int k = 0; k < NUM_DIGITS; k++)
                if (CW'(k) == digit_count) dig_q[k] <= num;
              digit_count <= digit_count + CW'(1);
              if (digit_count == CW'(NUM_DIGITS-1)) state <= READY;
            end
          end
        end
        READY: begin
          if (finish) state <= CHECK;
        end
        CHECK: begin
          match_count <= match_c;
          prize       <= prize_c;
          win         <= |prize_c;
          done        <= 1'b1;
          if (games_played != {CNT_W{1'b1}})
            games_played <= games_played + CNT_W'(1);
          state <= RESULT;
        end
        RESULT: begin
          // finish is ignored here, so new_game wins when both are high.
          if (new_game) begin
            dig_q       <= '0;
            digit_count <= '0;
            match_count <= '0;
            prize       <= 2'd0;
            win         <= 1'b0;
            done        <= 1'b0;
            state       <= ENTRY;
          end
        end
        default: state <= ENTRY;
      endcase
    end
  end

endmodule

// File: tb/tb_lottery_checker_param.sv
// Directed testbench for lottery_checker_param (default parameters).
module tb_lottery_checker_param;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  num;
  logic        insert, finish, new_game, load_secret;
  logic [19:0] secret_in;
  logic [19:0] digits;
  logic [2:0]  digit_count, match_count;
  logic [1:0]  prize;
  logic        win, done, bad_digit;
  logic [7:0]  games_played;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  lottery_checker_param dut (
    .clk(clk), .reset(reset), .num(num), .insert(insert), .finish(finish),
    .new_game(new_game), .load_secret(load_secret), .secret_in(secret_in),
    .digits(digits), .digit_count(digit_count), .match_count(match_count),
    .prize(prize), .win(win), .done(done), .bad_digit(bad_digit),
    .games_played(games_played)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ins(input logic [3:0] d);
    num = d; insert = 1'b1; tick();
    insert = 1'b0; tick();
  endtask

  task automatic enter(input logic [19:0] t);
    for (int k = 0; k < 5; k++) ins(t[k*4 +: 4]);
  endtask

  // Full ticket: enter, finish (held through RESULT), check result, new_game.
  task automatic play(input string tag, input logic [19:0] t, input logic [2:0] em,
                      input logic [1:0] ep, input logic ew, input logic [7:0] eg);
    enter(t);
    chk({tag, " digits"}, 32'(digits), 32'(t));
    chk({tag, " count"}, 32'(digit_count), 32'd5);
    finish = 1'b1; tick();
    chk({tag, " done_early"}, 32'(done), 32'd0);
    tick();
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " match"}, 32'(match_count), 32'(em));
    chk({tag, " prize"}, 32'(prize), 32'(ep));
    chk({tag, " win"}, 32'(win), 32'(ew));
    chk({tag, " games"}, 32'(games_played), 32'(eg));
    tick();
    chk({tag, " games_held"}, 32'(games_played), 32'(eg));
    finish = 1'b0;
    new_game = 1'b1; tick();
    new_game = 1'b0;
    chk({tag, " cleared_done"}, 32'(done), 32'd0);
    chk({tag, " cleared_count"}, 32'(digit_count), 32'd0);
    chk({tag, " cleared_digits"}, 32'(digits), 32'd0);
  endtask

  initial begin
    reset = 1'b1; num = '0; insert = 0; finish = 0; new_game = 0;
    load_secret = 0; secret_in = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst digits", 32'(digits), 32'd0);
    chk("rst count", 32'(digit_count), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst prize", 32'(prize), 32'd0);
    chk("rst games", 32'(games_played), 32'd0);
    chk("rst bad", 32'(bad_digit), 32'd0);

    // Default secret 5,0,9,6,7 packs to 20'h76905.
    play("jackpot", 20'h76905, 3'd5, 2'd3, 1'b1, 8'd1);
    play("prize1",  20'h16905, 3'd4, 2'd1, 1'b1, 8'd2);
    play("prize2",  20'h11905, 3'd3, 2'd2, 1'b1, 8'd3);
    play("none",    20'h76111, 3'd2, 2'd0, 1'b0, 8'd4);

    // Bad digit, held insert, early finish, insert in READY.
    ins(4'd1); ins(4'd1);
    num = 4'd12; insert = 1'b1; tick();
    chk("bad pulse", 32'(bad_digit), 32'd1);
    chk("bad count", 32'(digit_count), 32'd2);
    insert = 1'b0; tick();
    chk("bad pulse_end", 32'(bad_digit), 32'd0);
    ins(4'd9);
    chk("after_bad count", 32'(digit_count), 32'd3);
    chk("after_bad digits", 32'(digits), 32'h00911);
    finish = 1'b1; tick(); tick();
    finish = 1'b0;
    chk("early_finish done", 32'(done), 32'd0);
    chk("early_finish count", 32'(digit_count), 32'd3);
    num = 4'd3; insert = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    insert = 1'b0; tick();
    chk("held count", 32'(digit_count), 32'd4);
    ins(4'd4);
    ins(4'd8);
    chk("ready_ignore digits", 32'(digits), 32'h43911);
    chk("ready_ignore count", 32'(digit_count), 32'd5);
    finish = 1'b1; tick(); tick();
    chk("mixed match", 32'(match_count), 32'd1);
    chk("mixed prize", 32'(prize), 32'd0);
    chk("mixed games", 32'(games_played), 32'd5);
    // finish+new_game together with insert held high: new_game wins, no insert.
    num = 4'd7; insert = 1'b1; new_game = 1'b1; tick();
    new_game = 1'b0; finish = 1'b0; tick(); tick();
    chk("fin_ng done", 32'(done), 32'd0);
    chk("fin_ng games", 32'(games_played), 32'd5);
    chk("held_ng count", 32'(digit_count), 32'd0);
    insert = 1'b0; tick();

    // Secret load at count 0 is accepted, at count 2 is ignored.
    load_secret = 1'b1; secret_in = 20'h54321; tick();
    load_secret = 1'b0;
    play("loaded", 20'h54321, 3'd5, 2'd3, 1'b1, 8'd6);
    ins(4'd1); ins(4'd2);
    load_secret = 1'b1; secret_in = 20'h99999; tick();
    load_secret = 1'b0;
    ins(4'd3); ins(4'd4); ins(4'd5);
    finish = 1'b1; tick(); tick();
    finish = 1'b0;
    chk("late_load match", 32'(match_count), 32'd5);
    chk("late_load prize", 32'(prize), 32'd3);
    new_game = 1'b1; tick(); new_game = 1'b0;

    // Reset during CHECK.
    enter(20'h54321);
    finish = 1'b1; tick();
    reset = 1'b1; tick();
    reset = 1'b0; finish = 1'b0;
    chk("rst_chk done", 32'(done), 32'd0);
    chk("rst_chk games", 32'(games_played), 32'd0);
    chk("rst_chk count", 32'(digit_count), 32'd0);
    chk("rst_chk match", 32'(match_count), 32'd0);
    chk("rst_chk prize", 32'(prize), 32'd0);
    chk("rst_chk win", 32'(win), 32'd0);
    chk("rst_chk digits", 32'(digits), 32'd0);

    // Secret is back to the reset value after reset.
    play("post_rst", 20'h76905, 3'd5, 2'd3, 1'b1, 8'd1);

    // Saturation: 255 more games reach 256 total.
    for (int g = 0; g < 255; g++) begin
      enter(20'h11111);
      finish = 1'b1; tick(); tick();
      finish = 1'b0;
      new_game = 1'b1; tick(); new_game = 1'b0;
    end
    chk("sat games", 32'(games_played), 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
